multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports clk and rst_n are listed first.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock
- rst_n, in, 1, async active-low reset
- opcode, in, 4, instruction opcode from IR
- zero, in, 1, ALU zero flag
- mem_ready, in, 1, memory completes the current access this cycle
- mem_req, out, 1, memory access request
- mem_we, out, 1, write access
- iord, out, 1, memory address select: 0 PC, 1 ALU result register
- ir_we, out, 1, IR load
- pc_we, out, 1, PC load
- pc_src, out, 2, PC source: 00 ALU, 01 ALUOut, 10 jump target
- reg_we, out, 1, register-file write
- reg_dst, out, 1, destination: 1 rd, 0 rt
- mem_to_reg, out, 1, write-back source is MDR
- alu_src_a, out, 1, 0 PC, 1 rs
- alu_src_b, out, 2, 00 rt, 01 const 1, 10 sign-extended immediate
- alu_op, out, 3, code for the ALU control unit
- illegal_op, out, 1, one-cycle pulse on an unknown opcode
- state, out, 4, current state for debug

Function
REQ-003 SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state plus zero and mem_ready only.
REQ-004 SHALL use these states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP.
REQ-005 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ALUOP_ADD; when mem_ready=1, ir_we=1, pc_we=1, pc_src=00, and the FSM goes to DECODE; otherwise it holds in FETCH.
REQ-006 DECODE transitions by opcode:
- OP_R goes to EXEC_R.
- OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI go to EXEC_I.
- OP_LW, OP_SW go to MEM_ADDR.
- OP_BEQ, OP_BNE go to BRANCH.
- OP_J goes to JUMP.
- Any other opcode pulses illegal_op for one cycle and goes to FETCH.
REQ-007 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=ALUOP_RTYPE, then go to WB_R; WB_R SHALL drive reg_we=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-008 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op = the per-opcode package constant, then go to WB_I; WB_I SHALL drive reg_we=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-009 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=ALUOP_ADD, then go to MEM_RD for LW or MEM_WR for SW.
REQ-010 MEM_RD and MEM_WR SHALL hold mem_req=1 and iord=1 (mem_we=1 in MEM_WR only) until mem_ready=1. On mem_ready, MEM_RD goes to WB_MEM and MEM_WR goes to FETCH.
REQ-011 WB_MEM SHALL drive reg_we=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-012 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=ALUOP_SUB, pc_src=01, and pc_we = zero for BEQ or ~zero for BNE, then go to FETCH.
REQ-013 JUMP SHALL drive pc_we=1, pc_src=10, then go to FETCH.
REQ-014 The opcode SHALL be latched on leaving DECODE; opcode changes after that point SHALL NOT affect the instruction in progress.
REQ-015 Every output not named in a state SHALL be 0, including mem_req, all write enables and illegal_op.
REQ-016 mem_ready while mem_req=0 SHALL be ignored. mem_ready=1 in the first cycle of an access state SHALL complete that access in one cycle.

Reset
REQ-017 Asserting rst_n=0 SHALL, asynchronously, force state to FETCH, clear the latched opcode, and drive all outputs to their FETCH-without-ready values; this applies mid-access as well and discards the access.
REQ-018 The first mem_req after reset release SHALL appear in the first cycle with rst_n=1.

Configuration
REQ-019 With macro MULTICYCLE_CTRL_PERF_CNT_EN defined, the block SHALL add outputs instr_cnt (out, 16) and stall_cnt (out, 16):
- instr_cnt increments on every transition into FETCH from a completing state; it does not count illegal opcodes.
- stall_cnt increments every cycle with mem_req=1 and mem_ready=0.
- Both counters wrap at 16'hFFFF to 0 and reset to 0.
REQ-020 Without the macro, neither the ports nor the counters SHALL exist, and behaviour SHALL be otherwise identical.

Structure
REQ-021 A shared package multicycle_pkg SHALL hold:
- the state enum (4-bit);
- 4-bit opcodes: OP_R=0000, OP_ADDI=0100, OP_ANDI=0101, OP_ORI=0110, OP_SLTI=0111, OP_LW=1000, OP_SW=1001, OP_BEQ=1010, OP_BNE=1011, OP_J=1100;
- 3-bit alu_op constants: ALUOP_RTYPE=000, ALUOP_ADD=100, ALUOP_SUB=101, ALUOP_AND=110, ALUOP_OR=111, ALUOP_SLT=010.
REQ-022 One sub-module, multicycle_ctrl_decode (combinational state/opcode to control-word decode), SHALL be used; the state register stays in the top.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- R-type, mem_ready tied 1: FETCH, DECODE, EXEC_R, WB_R, FETCH in 4 cycles; reg_we=1, reg_dst=1 in the WB_R cycle; alu_op=000 in EXEC_R.
- LW with mem_ready low 3 cycles in MEM_RD: mem_req/iord held 4 cycles, then WB_MEM with mem_to_reg=1; stall_cnt=3 (macro on).
- BEQ with zero=1: pc_we=1, pc_src=01. BNE with zero=1: pc_we=0. Both return to FETCH.
- Opcode 1111: illegal_op=1 for exactly one cycle in DECODE, next state FETCH, instr_cnt unchanged.
- rst_n dropped mid-MEM_WR: mem_we and mem_req go 0 immediately, state=FETCH; after release the next fetch proceeds normally.
- 65536 retired ADDI instructions: instr_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_pkg: shared types and constants for the multicycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, opcode and alu_op constants, decoded control word.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_R     = 4'd7,
    WB_I     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_ORI  = 4'b0110;
  localparam logic [3:0] OP_SLTI = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_J    = 4'b1100;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_SUB   = 3'b101;
  localparam logic [2:0] ALUOP_AND   = 3'b110;
  localparam logic [2:0] ALUOP_OR    = 3'b111;
  localparam logic [2:0] ALUOP_SLT   = 3'b010;

  // One decoded control word; the top fans it out onto the interface.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // ALU code for the immediate-arithmetic group.
  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALUOP_AND;
      OP_ORI:  imm_alu_op = ALUOP_OR;
      OP_SLTI: imm_alu_op = ALUOP_SLT;
      default: imm_alu_op = ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stalls the controller in access states.
// master = controller (drives controls, state); slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational state/opcode -> control word + next state.
// Latency: 0 cycles (pure combinational).
// Backpressure: mem_ready=0 holds FETCH/MEM_RD/MEM_WR in place.
// Ports: state, opcode (live, used in DECODE), op_q (latched), zero, mem_ready -> ctl, next.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [3:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctl,
  output state_t     next
);

  always_comb begin
    ctl  = '0;
    next = state;
    case (state)
      FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctl.ir_we = 1'b1;
          ctl.pc_we = 1'b1;
          next      = DECODE;
        end
      end
      // Only state that looks at the live opcode; later states use op_q.
      DECODE: begin
        case (opcode)
          OP_R:                             next = EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next = EXEC_I;
          OP_LW, OP_SW:                     next = MEM_ADDR;
          OP_BEQ, OP_BNE:                   next = BRANCH;
          OP_J:                             next = JUMP;
          default: begin
            ctl.illegal_op = 1'b1;
            next           = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b00;
        ctl.alu_op    = ALUOP_RTYPE;
        next          = WB_R;
      end
      EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = imm_alu_op(op_q);
        next          = WB_I;
      end
      MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = ALUOP_ADD;
        next          = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) next = WB_MEM;
      end
      MEM_WR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) next = FETCH;
      end
      WB_R: begin
        ctl.reg_we  = 1'b1;
        ctl.reg_dst = 1'b1;
        next        = FETCH;
      end
      WB_I: begin
        ctl.reg_we = 1'b1;
        next       = FETCH;
      end
      WB_MEM: begin
        ctl.reg_we     = 1'b1;
        ctl.mem_to_reg = 1'b1;
        next           = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b00;
        ctl.alu_op    = ALUOP_SUB;
        ctl.pc_src    = 2'b01;
        ctl.pc_we     = (op_q == OP_BNE) ? ~zero : zero;
        next          = FETCH;
      end
      JUMP: begin
        ctl.pc_we  = 1'b1;
        ctl.pc_src = 2'b10;
        next       = FETCH;
      end
      default: next = FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle CPU datapath.
// Latency: 3-5 cycles per instruction plus memory wait cycles.
// Backpressure: holds in FETCH/MEM_RD/MEM_WR until mem_ready.
// Ports: clk, rst_n, bus (multicycle_ctrl_if.master); with MULTICYCLE_CTRL_PERF_CNT_EN
// defined also instr_cnt/stall_cnt (16-bit wrapping retire and memory-stall counters).
module multicycle_ctrl
  import multicycle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]        instr_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] op_q;
  ctrl_t      ctl;
  logic       rdy;

  // While reset is held the FSM sits in FETCH: mem_ready is masked so no
  // IR/PC load fires, and mem_req is masked so no access starts until release.
  assign rdy = bus.mem_ready & rst_n;

  multicycle_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .op_q      (op_q),
    .zero      (bus.zero),
    .mem_ready (rdy),
    .ctl       (ctl),
    .next      (state_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
    end
  end

  assign bus.mem_req    = ctl.mem_req & rst_n;
  assign bus.mem_we     = ctl.mem_we;
  assign bus.iord       = ctl.iord;
  assign bus.ir_we      = ctl.ir_we;
  assign bus.pc_we      = ctl.pc_we;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.reg_we     = ctl.reg_we;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_op     = ctl.alu_op;
  assign bus.illegal_op = ctl.illegal_op;
  assign bus.state      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  // Retire = entering FETCH from any state other than FETCH itself or
  // DECODE (DECODE->FETCH is the illegal-opcode path).
  logic retire;
  assign retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != DECODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire)                instr_cnt <= instr_cnt + 16'd1;
      if (ctl.mem_req && !rdy)   stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] stall_cnt;
`endif

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int instr_model = 0;
  int stall_model = 0;

  // One expected cycle: state, output word, and mem_ready drive (0, 1, 2=random).
  typedef struct {
    logic [3:0]  st;
    logic [16:0] word;
    logic [1:0]  rdy;
  } step_t;
  step_t plan[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] w(input logic mreq, input logic mwe, input logic iord,
                                    input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                    input logic rwe, input logic rdst, input logic m2r,
                                    input logic sa, input logic [1:0] sb,
                                    input logic [2:0] aop, input logic ill);
    return {mreq, mwe, iord, irwe, pcwe, pcs, rwe, rdst, m2r, sa, sb, aop, ill};
  endfunction

  function automatic logic [16:0] obs_word();
    return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src,
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.illegal_op};
  endfunction

  task automatic push(input logic [3:0] st, input logic [16:0] wd, input logic [1:0] rdy);
    step_t s;
    s.st = st; s.word = wd; s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Called at a falling edge; leaves at a falling edge after the last step.
  task automatic run_plan(input logic [3:0] op, input logic zero, input string tag);
    foreach (plan[i]) begin
      bus.zero      = zero;
      bus.mem_ready = (plan[i].rdy == 2'd2) ? 1'($urandom % 2) : plan[i].rdy[0];
      // Opcode only valid through DECODE; scrambled afterwards.
      bus.opcode    = (plan[i].st == FETCH || plan[i].st == DECODE) ? op : 4'($urandom);
      #1;
      chk($sformatf("%s.st%0d", tag, i), 32'(bus.state), 32'(plan[i].st));
      chk($sformatf("%s.out%0d", tag, i), 32'(obs_word()), 32'(plan[i].word));
      @(negedge clk);
    end
    plan.delete();
  endtask

  task automatic fetch_steps(input int fst);
    for (int k = 0; k < fst; k++) begin
      push(FETCH, w(1,0,0,0,0,2'b00,0,0,0,0,2'b01,ALUOP_ADD,0), 2'd0);
      stall_model++;
    end
    push(FETCH, w(1,0,0,1,1,2'b00,0,0,0,0,2'b01,ALUOP_ADD,0), 2'd1);
  endtask

  // Expected behaviour of one instruction, by instruction class.
  task automatic exec(input logic [3:0] op, input logic zero, input int fst, input int mst,
                      input string tag);
    logic [2:0]  aop;
    logic [3:0]  acc_st;
    logic [16:0] acc_w;
    logic [16:0] none;
    none = '0;
    fetch_steps(fst);
    case (op)
      OP_R: begin
        push(DECODE, none, 2'd2);
        push(EXEC_R, w(0,0,0,0,0,2'b00,0,0,0,1,2'b00,ALUOP_RTYPE,0), 2'd2);
        push(WB_R,   w(0,0,0,0,0,2'b00,1,1,0,0,2'b00,3'b000,0), 2'd2);
        instr_model++;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        aop = (op == OP_ADDI) ? ALUOP_ADD : (op == OP_ANDI) ? ALUOP_AND :
              (op == OP_ORI)  ? ALUOP_OR  : ALUOP_SLT;
        push(DECODE, none, 2'd2);
        push(EXEC_I, w(0,0,0,0,0,2'b00,0,0,0,1,2'b10,aop,0), 2'd2);
        push(WB_I,   w(0,0,0,0,0,2'b00,1,0,0,0,2'b00,3'b000,0), 2'd2);
        instr_model++;
      end
      OP_LW, OP_SW: begin
        push(DECODE, none, 2'd2);
        push(MEM_ADDR, w(0,0,0,0,0,2'b00,0,0,0,1,2'b10,ALUOP_ADD,0), 2'd2);
        acc_st = (op == OP_LW) ? MEM_RD : MEM_WR;
        acc_w  = w(1, op == OP_SW, 1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0);
        for (int k = 0; k < mst; k++) begin
          push(acc_st, acc_w, 2'd0);
          stall_model++;
        end
        push(acc_st, acc_w, 2'd1);
        if (op == OP_LW) push(WB_MEM, w(0,0,0,0,0,2'b00,1,0,1,0,2'b00,3'b000,0), 2'd2);
        instr_model++;
      end
      OP_BEQ, OP_BNE: begin
        push(DECODE, none, 2'd2);
        push(BRANCH, w(0,0,0,0, (op == OP_BEQ) ? zero : ~zero, 2'b01,0,0,0,1,2'b00,
                       ALUOP_SUB,0), 2'd2);
        instr_model++;
      end
      OP_J: begin
        push(DECODE, none, 2'd2);
        push(JUMP, w(0,0,0,0,1,2'b10,0,0,0,0,2'b00,3'b000,0), 2'd2);
        instr_model++;
      end
      default: begin
        push(DECODE, w(0,0,0,0,0,2'b00,0,0,0,0,2'b00,3'b000,1), 2'd2);
      end
    endcase
    run_plan(op, zero, tag);
    chk({tag, ".back_to_fetch"}, 32'(bus.state), 32'(FETCH));
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chk({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(16'(instr_model)));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(16'(stall_model)));
`endif
  endtask

  logic [16:0] rst_word;

  initial begin
    rst_word = w(0,0,0,0,0,2'b00,0,0,0,0,2'b01,ALUOP_ADD,0);
    rst_n = 1'b0;
    bus.opcode = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset.state", 32'(bus.state), 32'(FETCH));
    chk("reset.out", 32'(obs_word()), 32'(rst_word));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    exec(OP_R,    1'b0, 0, 0, "rtype");
    exec(OP_LW,   1'b0, 0, 3, "lw_stall3");
    exec(OP_BEQ,  1'b1, 0, 0, "beq_z1");
    exec(OP_BNE,  1'b1, 0, 0, "bne_z1");
    exec(4'b1111, 1'b0, 0, 0, "illegal");
    exec(OP_SW,   1'b0, 1, 2, "sw");
    exec(OP_J,    1'b0, 2, 0, "jump");

    // Reset dropped in the middle of a store.
    push(FETCH, w(1,0,0,1,1,2'b00,0,0,0,0,2'b01,ALUOP_ADD,0), 2'd1);
    push(DECODE, '0, 2'd2);
    push(MEM_ADDR, w(0,0,0,0,0,2'b00,0,0,0,1,2'b10,ALUOP_ADD,0), 2'd2);
    push(MEM_WR, w(1,1,1,0,0,2'b00,0,0,0,0,2'b00,3'b000,0), 2'd0);
    run_plan(OP_SW, 1'b0, "swrst");
    bus.mem_ready = 1'b0;
    #1;
    chk("swrst.pre_we", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("swrst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("swrst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("swrst.state", 32'(bus.state), 32'(FETCH));
    instr_model = 0;
    stall_model = 0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("swrst.held", 32'(obs_word()), 32'(rst_word));
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    chk("swrst.instr_cnt", 32'(instr_cnt), 32'd0);
    chk("swrst.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // First step of this fetch samples mem_req in the first cycle out of reset.
    exec(OP_ADDI, 1'b0, 0, 0, "post_rst");

    // Randomized instruction mix, including illegal opcodes.
    for (int n = 0; n < 150; n++) begin
      exec(4'($urandom_range(0, 15)), 1'($urandom % 2), $urandom_range(0, 2),
           $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    // Counter wrap: 65535 ADDIs reach FFFF, one more returns to 0.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    instr_model = 0;
    stall_model = 0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_ADDI;
    repeat (4 * 65535) @(negedge clk);
    instr_model = 65535;
    #1;
    chk("wrap.ffff", 32'(instr_cnt), 32'(16'(instr_model)));
    repeat (4) @(negedge clk);
    instr_model = 65536;
    #1;
    chk("wrap.zero", 32'(instr_cnt), 32'(16'(instr_model)));
    chk("wrap.stall", 32'(stall_cnt), 32'(16'(stall_model)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
